// File: rtl/lcd_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_ctrl
// HD44780-style character-LCD write sequencer. Sits behind the LSU LCD output
// register: every flip of the TOG bit is a new write request, which is either
// started immediately or parked in a one-deep pending slot. The block then
// drives RS/DATA with setup, EN pulse, hold and execution-wait timing.
//
// Optional feature (compile-time macro LCD_INIT_SEQ_EN): after reset, wait
// POWERUP_CYC cycles and issue the init sequence 0x38, 0x0C, 0x01, 0x06.
//
// Ports:
//   i_clk        - clock
//   i_reset      - synchronous, active-high reset
//   i_io_lcd     - LCD register: [31]=ON, [30]=TOG, [10]=RS, [7:0]=DATA
//   o_lcd_on     - registered copy of ON
//   o_lcd_en     - EN strobe (high only in PULSE)
//   o_lcd_rs     - register select (0 = command, 1 = data)
//   o_lcd_rw     - always 0 (write-only)
//   o_lcd_data   - LCD data bus
//   o_lcd_status - {30'b0, overrun, busy}
//
// Handshake: there is no valid/ready pair. A request is valid in any cycle
// where i_io_lcd[30] differs from the last sampled TOG; it is always accepted
// (started, parked in pending, or overwriting pending with overrun set).
// -----------------------------------------------------------------------------
module lcd_ctrl #(
   parameter int SETUP_CYC      = 2,
   parameter int EN_HIGH_CYC    = 25,
   parameter int HOLD_CYC       = 2,
   parameter int EXEC_CYC       = 2000,
   parameter int CLEAR_EXEC_CYC = 82000,
   parameter int POWERUP_CYC    = 750000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_io_lcd,
   output logic        o_lcd_on,
   output logic        o_lcd_en,
   output logic        o_lcd_rs,
   output logic        o_lcd_rw,
   output logic [7:0]  o_lcd_data,
   output logic [31:0] o_lcd_status
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, EN_HIGH_CYC), max2(HOLD_CYC, EXEC_CYC)),
                                 max2(CLEAR_EXEC_CYC, POWERUP_CYC));
   localparam int CW = $clog2(MAX_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SETUP    = 3'd1,
      S_PULSE    = 3'd2,
      S_HOLD     = 3'd3,
      S_WAIT     = 3'd4,
      S_INIT_PWR = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            tog_q;
   logic            rs_q, rs_d;
   logic [7:0]      data_q, data_d;
   logic            pend_valid_q, pend_valid_d;
   logic [8:0]      pend_cmd_q, pend_cmd_d;
   logic            overrun_q, overrun_d;
   logic            en_q;
   logic            on_q;

   logic            req;
   logic [8:0]      req_cmd;
   logic            is_long;
   logic            launch;
   logic [8:0]      launch_cmd;
   logic            wait_done;
   logic            init_more;
   logic            busy;
   logic            unused_bits;

`ifdef LCD_INIT_SEQ_EN
   logic            init_run_q, init_run_d;
   logic [1:0]      init_idx_q, init_idx_d;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return 8'h38;
         2'd1:    return 8'h0C;
         2'd2:    return 8'h01;
         default: return 8'h06;
      endcase
   endfunction
`endif

   assign req         = i_io_lcd[30] ^ tog_q;
   assign req_cmd     = {i_io_lcd[10], i_io_lcd[7:0]};
   assign unused_bits = ^{i_io_lcd[29:11], i_io_lcd[9:8]};
   // Clear and Home need the long execution wait.
   assign is_long     = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);
   assign busy        = (state_q != S_IDLE) || pend_valid_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rs_d         = rs_q;
      data_d       = data_q;
      pend_valid_d = pend_valid_q;
      pend_cmd_d   = pend_cmd_q;
      overrun_d    = overrun_q;
      launch       = 1'b0;
      launch_cmd   = '0;
      wait_done    = 1'b0;
      init_more    = 1'b0;
`ifdef LCD_INIT_SEQ_EN
      init_run_d   = init_run_q;
      init_idx_d   = init_idx_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (req) begin
               launch     = 1'b1;
               launch_cmd = req_cmd;
            end
         end
         S_SETUP: begin
            if (cnt_q == '0) begin
               state_d = S_PULSE;
               cnt_d   = CW'(EN_HIGH_CYC - 1);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_PULSE: begin
            if (cnt_q == '0) begin
               state_d = S_HOLD;
               cnt_d   = CW'(HOLD_CYC - 1);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_HOLD: begin
            if (cnt_q == '0) begin
               state_d = S_WAIT;
               cnt_d   = is_long ? CW'(CLEAR_EXEC_CYC - 1) : CW'(EXEC_CYC - 1);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               wait_done = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_INIT_PWR: begin
`ifdef LCD_INIT_SEQ_EN
            if (cnt_q == '0) begin
               launch     = 1'b1;
               launch_cmd = {1'b0, init_cmd(2'd0)};
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
`else
            state_d = S_IDLE;
`endif
         end
         default: state_d = S_IDLE;
      endcase

      if (wait_done) begin
`ifdef LCD_INIT_SEQ_EN
         // The init sequence has priority over software requests.
         if (init_run_q && init_idx_q != 2'd3) begin
            init_more  = 1'b1;
            init_idx_d = init_idx_q + 2'd1;
            launch     = 1'b1;
            launch_cmd = {1'b0, init_cmd(init_idx_q + 2'd1)};
         end else begin
            init_run_d = 1'b0;
         end
`endif
         if (!init_more) begin
            if (pend_valid_q) begin
               // Launch the parked command; a simultaneous request takes its
               // place without counting as an overrun.
               launch       = 1'b1;
               launch_cmd   = pend_cmd_q;
               pend_valid_d = req;
               if (req) pend_cmd_d = req_cmd;
            end else if (req) begin
               launch     = 1'b1;
               launch_cmd = req_cmd;
            end else begin
               state_d = S_IDLE;
            end
         end
      end

      // Requests while a command is in flight are parked (newest wins).
      if (req && state_q != S_IDLE && !(wait_done && !init_more)) begin
         pend_valid_d = 1'b1;
         pend_cmd_d   = req_cmd;
         if (pend_valid_q) overrun_d = 1'b1;
      end

      if (launch) begin
         state_d = S_SETUP;
         cnt_d   = CW'(SETUP_CYC - 1);
         rs_d    = launch_cmd[8];
         data_d  = launch_cmd[7:0];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
`ifdef LCD_INIT_SEQ_EN
         state_q    <= S_INIT_PWR;
         cnt_q      <= CW'(POWERUP_CYC - 1);
         init_run_q <= 1'b1;
         init_idx_q <= 2'd0;
`else
         state_q    <= S_IDLE;
         cnt_q      <= '0;
`endif
         tog_q        <= 1'b0;
         rs_q         <= 1'b0;
         data_q       <= 8'h00;
         pend_valid_q <= 1'b0;
         pend_cmd_q   <= '0;
         overrun_q    <= 1'b0;
         en_q         <= 1'b0;
         on_q         <= 1'b0;
      end else begin
`ifdef LCD_INIT_SEQ_EN
         init_run_q <= init_run_d;
         init_idx_q <= init_idx_d;
`endif
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         tog_q        <= i_io_lcd[30];
         rs_q         <= rs_d;
         data_q       <= data_d;
         pend_valid_q <= pend_valid_d;
         pend_cmd_q   <= pend_cmd_d;
         overrun_q    <= overrun_d;
         en_q         <= (state_d == S_PULSE);
         on_q         <= i_io_lcd[31];
      end
   end

   assign o_lcd_on     = on_q;
   assign o_lcd_en     = en_q;
   assign o_lcd_rs     = rs_q;
   assign o_lcd_rw     = 1'b0;
   assign o_lcd_data   = data_q;
   assign o_lcd_status = {30'b0, overrun_q, busy};

endmodule
